// File: rtl/kuznechik_decrypt_ctrl.sv
// rtl/kuznechik_decrypt_ctrl.sv - Kuznechik decrypt sequencer: key hold, ECB/CBC chaining, credit issue, output FIFO
//
// Feeds ciphertext blocks into one external OptKuznechikDecoder with
// DEC_LATENCY pipeline stages and collects the plaintext in an output FIFO.
// A block is only issued when a FIFO slot is guaranteed for it, so a stalled
// consumer can never cause a result to be dropped.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   key_valid/key_ready           load key_in, iv_in and cbc_in (1 = CBC)
//   ct_valid/ct_ready/ct_data     ciphertext input stream
//   pt_valid/pt_ready/pt_data     plaintext output stream (FIFO head)
//   dec_encoded, dec_key          to the decoder (.encoded, .key)
//   dec_block                     from the decoder (.block)
//   busy                          blocks in flight or FIFO not empty

module kuznechik_decrypt_ctrl #(
    parameter int DEC_LATENCY = 0,
    parameter int OUT_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key_in,
    input  logic [127:0] iv_in,
    input  logic         cbc_in,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [127:0] ct_data,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [127:0] pt_data,
    output logic [127:0] dec_encoded,
    output logic [255:0] dec_key,
    input  logic [127:0] dec_block,
    output logic         busy
);

    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(OUT_DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(OUT_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [255:0]  key_q;
    logic [127:0]  chain_q;
    logic          cbc_q;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [127:0]  fifo_mem [OUT_DEPTH];

    logic          key_acc;
    logic          issue;
    logic          retire;
    logic          retire_cbc;
    logic [127:0]  retire_chain;
    logic [127:0]  retire_data;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // Every in-flight block and every stored result holds one FIFO credit.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};

    assign key_ready = (state == NOKEY) || ((state == DRAIN) && (inflight == '0));
    assign key_acc   = key_valid && key_ready;
    // A pending key load blocks new ciphertext so the drain can complete.
    assign ct_ready  = (state == RUN) && !key_valid && (credit_used < DEPTH_W);
    assign issue     = ct_valid && ct_ready;

    assign dec_encoded = issue ? ct_data : '0;
    assign dec_key     = key_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NOKEY;
            key_q   <= '0;
            chain_q <= '0;
            cbc_q   <= 1'b0;
        end else begin
            case (state)
                NOKEY:   if (key_valid) state <= RUN;
                RUN:     if (key_valid) state <= DRAIN;
                DRAIN:   if (inflight == '0) state <= RUN;
                default: state <= NOKEY;
            endcase
            if (key_acc) begin
                key_q   <= key_in;
                chain_q <= iv_in;
                cbc_q   <= cbc_in;
            end else if (issue) begin
                chain_q <= ct_data;
            end
        end
    end

    // Tag pipeline: carries the chain value and mode of each issued block
    // alongside the decoder so the XOR at retire uses that block's context.
    generate
        if (DEC_LATENCY == 0) begin : g_comb
            assign retire       = issue;
            assign retire_chain = chain_q;
            assign retire_cbc   = cbc_q;
        end else begin : g_pipe
            logic [DEC_LATENCY-1:0] tag_v;
            logic [DEC_LATENCY-1:0] tag_cbc;
            logic [127:0]           tag_chain [DEC_LATENCY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_v   <= '0;
                    tag_cbc <= '0;
                    for (int i = 0; i < DEC_LATENCY; i++) tag_chain[i] <= '0;
                end else begin
                    tag_v[0]     <= issue;
                    tag_cbc[0]   <= cbc_q;
                    tag_chain[0] <= chain_q;
                    for (int i = 1; i < DEC_LATENCY; i++) begin
                        tag_v[i]     <= tag_v[i-1];
                        tag_cbc[i]   <= tag_cbc[i-1];
                        tag_chain[i] <= tag_chain[i-1];
                    end
                end
            end

            assign retire       = tag_v[DEC_LATENCY-1];
            assign retire_chain = tag_chain[DEC_LATENCY-1];
            assign retire_cbc   = tag_cbc[DEC_LATENCY-1];
        end
    endgenerate

    assign retire_data = dec_block ^ (retire_cbc ? retire_chain : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (issue && !retire) begin
            inflight <= inflight + 1'b1;
        end else if (retire && !issue) begin
            inflight <= inflight - 1'b1;
        end
    end

    assign push     = retire;
    assign pt_valid = (fifo_count != '0);
    assign pop      = pt_valid && pt_ready;
    assign pt_data  = pt_valid ? fifo_mem[rd_ptr] : '0;
    assign busy     = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by fifo_count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= retire_data;
        if (!rst) assert (!(push && !pop && (fifo_count == FULL_C)));
    end

endmodule

// File: tb/tb_kuznechik_decrypt_ctrl.sv
// tb/tb_kuznechik_decrypt_ctrl.sv - self-checking bench for kuznechik_decrypt_ctrl
module tb_kuznechik_decrypt_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    localparam logic [255:0] K1 = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] CT1 = 128'h7f679d90bebc24305a468d42b9d4edcd;

    // Stand-in for the decoder: any fixed invertible-looking function of block and key.
    function automatic logic [127:0] fake_dec(input logic [127:0] e, input logic [255:0] k);
        return {e[119:0], e[127:120]} ^ k[255:128] ^ ~k[127:0];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // DEC_LATENCY = 0 instance
    logic         a_key_valid, a_key_ready, a_cbc_in, a_ct_valid, a_ct_ready;
    logic         a_pt_valid, a_pt_ready, a_busy;
    logic [255:0] a_key_in, a_dec_key;
    logic [127:0] a_iv_in, a_ct_data, a_pt_data, a_dec_encoded, a_dec_block;

    assign a_dec_block = fake_dec(a_dec_encoded, a_dec_key);

    kuznechik_decrypt_ctrl #(.DEC_LATENCY(0), .OUT_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst),
        .key_valid(a_key_valid), .key_ready(a_key_ready), .key_in(a_key_in),
        .iv_in(a_iv_in), .cbc_in(a_cbc_in),
        .ct_valid(a_ct_valid), .ct_ready(a_ct_ready), .ct_data(a_ct_data),
        .pt_valid(a_pt_valid), .pt_ready(a_pt_ready), .pt_data(a_pt_data),
        .dec_encoded(a_dec_encoded), .dec_key(a_dec_key), .dec_block(a_dec_block),
        .busy(a_busy)
    );

    // DEC_LATENCY = 3 instance
    logic         key_valid, key_ready, cbc_in, ct_valid, ct_ready;
    logic         pt_valid, pt_ready, busy;
    logic [255:0] key_in, dec_key;
    logic [127:0] iv_in, ct_data, pt_data, dec_encoded, dec_block;
    logic [127:0] p0 = '0, p1 = '0, p2 = '0;

    // Key is applied at the last stage, so a key change with blocks in flight corrupts them.
    always @(posedge clk) begin
        p0 <= dec_encoded;
        p1 <= p0;
        p2 <= p1;
    end
    assign dec_block = fake_dec(p2, dec_key);

    kuznechik_decrypt_ctrl #(.DEC_LATENCY(3), .OUT_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .iv_in(iv_in), .cbc_in(cbc_in),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .dec_encoded(dec_encoded), .dec_key(dec_key), .dec_block(dec_block),
        .busy(busy)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_pop    = 0;
    logic ct_acc = 1'b0;

    // Reference model: expected plaintexts in acceptance order.
    logic [127:0] exp_q[$];
    logic [255:0] m_key   = '0;
    logic [127:0] m_chain = '0;
    logic         m_cbc   = 1'b0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of the latency-3 instance: record handshakes, then advance.
    task automatic tick();
        #1;
        ct_acc = ct_valid && ct_ready;
        if (key_valid && key_ready) begin
            m_key   = key_in;
            m_chain = iv_in;
            m_cbc   = cbc_in;
        end
        if (pt_ready) begin
            if (exp_q.size() == 0) begin
                check1("pt_ghost", pt_valid, 1'b0);
            end else if (pt_valid) begin
                check128("pt_data", pt_data, exp_q.pop_front());
                n_pop++;
            end
        end
        if (ct_acc) begin
            exp_q.push_back(fake_dec(ct_data, m_key) ^ (m_cbc ? m_chain : 128'h0));
            m_chain = ct_data;
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [255:0] k, input logic [127:0] iv, input logic c);
        logic got;
        key_valid = 1'b1;
        key_in    = k;
        iv_in     = iv;
        cbc_in    = c;
        got       = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            #1 got = key_ready;
            tick();
        end
        key_valid = 1'b0;
        check1("key_accept", got, 1'b1);
    endtask

    task automatic drain(input string tag);
        pt_ready = 1'b1;
        ct_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        checkint(tag, exp_q.size(), 0);
    endtask

    int base;

    initial begin
        rst = 1'b1;
        a_key_valid = 0; a_key_in = '0; a_iv_in = '0; a_cbc_in = 0;
        a_ct_valid = 0; a_ct_data = '0; a_pt_ready = 0;
        key_valid = 0; key_in = '0; iv_in = '0; cbc_in = 0;
        ct_valid = 0; ct_data = '0; pt_ready = 0;

        #2;
        check1("rst_key_ready", key_ready, 1'b1);
        check1("rst_ct_ready", ct_ready, 1'b0);
        check1("rst_pt_valid", pt_valid, 1'b0);
        check128("rst_pt_data", pt_data, 128'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst0_ct_ready", a_ct_ready, 1'b0);
        check128("rst0_dec_encoded", a_dec_encoded, 128'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: ECB, combinational decoder, result one cycle after accept
        a_key_valid = 1; a_key_in = K1; a_iv_in = '0; a_cbc_in = 0;
        #1 check1("t1_key_ready", a_key_ready, 1'b1);
        @(posedge clk);
        #1 a_key_valid = 0; a_ct_valid = 1; a_ct_data = CT1;
        #1 check1("t1_ct_ready", a_ct_ready, 1'b1);
        check128("t1_dec_encoded", a_dec_encoded, CT1);
        @(posedge clk);
        #1 a_ct_valid = 0;
        #1 check1("t1_pt_valid", a_pt_valid, 1'b1);
        check128("t1_pt_data", a_pt_data, fake_dec(CT1, K1));
        check128("t1_enc_idle", a_dec_encoded, 128'h0);
        check1("t1_busy", a_busy, 1'b1);
        a_pt_ready = 1;
        @(posedge clk);
        #1 check1("t1_pt_empty", a_pt_valid, 1'b0);

        // T2: CBC with iv=1, two identical blocks back to back
        a_key_valid = 1; a_iv_in = 128'h1; a_cbc_in = 1;
        #1 check1("t2_ct_ready_keyprio", a_ct_ready, 1'b0);
        check1("t2_key_ready_run", a_key_ready, 1'b0);
        @(posedge clk);
        #1 check1("t2_key_ready_drain", a_key_ready, 1'b1);
        @(posedge clk);
        #1 a_key_valid = 0; a_ct_valid = 1; a_ct_data = CT1;
        @(posedge clk);
        #1 check1("t2_pt_valid", a_pt_valid, 1'b1);
        check128("t2_pt_first", a_pt_data, fake_dec(CT1, K1) ^ 128'h1);
        @(posedge clk);
        #1 a_ct_valid = 0;
        check128("t2_pt_second", a_pt_data, fake_dec(CT1, K1) ^ CT1);
        @(posedge clk);
        #1 check1("t2_pt_empty", a_pt_valid, 1'b0);
        check1("t2_busy", a_busy, 1'b0);

        // Latency 3: first result appears at issue+4
        load_key({rnd128(), rnd128()}, rnd128(), 1'b1);
        pt_ready = 0; ct_valid = 1; ct_data = rnd128();
        tick();
        ct_valid = 0;
        check1("lat_t1", pt_valid, 1'b0);
        tick();
        check1("lat_t2", pt_valid, 1'b0);
        tick();
        check1("lat_t3", pt_valid, 1'b0);
        tick();
        check1("lat_t4", pt_valid, 1'b1);
        check128("lat_data", pt_data, exp_q[0]);
        drain("lat_drain");

        // T3: consumer stalled, credit limit of 4
        base = n_acc;
        pt_ready = 0; ct_valid = 1; ct_data = rnd128();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ct_acc) ct_data = rnd128();
        end
        checkint("t3_accepts", n_acc - base, 4);
        check1("t3_ct_ready_full", ct_ready, 1'b0);
        check1("t3_busy", busy, 1'b1);
        base = n_pop;
        drain("t3_drain");
        checkint("t3_pops", n_pop - base, 4);
        #1 check1("t3_ct_ready_free", ct_ready, 1'b1);

        // T4: key change while streaming
        pt_ready = 1; ct_valid = 1; ct_data = rnd128();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ct_acc) ct_data = rnd128();
        end
        key_valid = 1; key_in = {rnd128(), rnd128()}; iv_in = rnd128(); cbc_in = 0;
        #1 check1("t4_ct_ready_drop", ct_ready, 1'b0);
        check1("t4_key_ready_run", key_ready, 1'b0);
        load_key(key_in, iv_in, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ct_acc) ct_data = rnd128();
        end
        drain("t4_drain");

        // T5: reset with two in flight and one in the FIFO
        pt_ready = 0; ct_valid = 1; ct_data = rnd128();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ct_acc) ct_data = rnd128();
        end
        ct_valid = 0;
        tick();
        check1("t5_pre_pt_valid", pt_valid, 1'b1);
        rst = 1;
        #1 check1("t5_pt_valid", pt_valid, 1'b0);
        check1("t5_busy", busy, 1'b0);
        check1("t5_ct_ready", ct_ready, 1'b0);
        check1("t5_key_ready", key_ready, 1'b1);
        exp_q.delete();
        m_key = '0; m_chain = '0; m_cbc = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        pt_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        check1("t5_no_ghost_busy", busy, 1'b0);

        // T6: random stalls, 1000 blocks
        load_key({rnd128(), rnd128()}, rnd128(), 1'b1);
        base = n_acc;
        n_pop = 0;
        ct_valid = 0;
        ct_acc = 0;
        for (int cyc = 0; cyc < 20000 && ((n_acc - base) < 1000 || exp_q.size() != 0); cyc++) begin
            if (!ct_valid || ct_acc) begin
                ct_valid = ((n_acc - base) < 1000) && ($urandom_range(0, 3) != 0);
                ct_data  = rnd128();
            end
            pt_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        ct_valid = 0;
        checkint("t6_accepts", n_acc - base, 1000);
        checkint("t6_pops", n_pop, 1000);
        checkint("t6_left", exp_q.size(), 0);
        check1("t6_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
